// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the PicoBlaze interrupt sequencer: the sequencer state
// encoding, default widths and the ISR entry address.
package int_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDR_W     = 12;
    localparam logic [11:0] DEFAULT_ISR_VECTOR = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        ISR  = 2'd2
    } state_t;

    // ENABLE/DISABLE INTERRUPT outside an ISR; DISABLE wins if both decode.
    function automatic logic ie_update(input logic ie_cur, input logic eint, input logic dint);
        logic ie_new;
        ie_new = ie_cur;
        if (dint) begin
            ie_new = 1'b0;
        end else if (eint) begin
            ie_new = 1'b1;
        end
        return ie_new;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Core-side bundle between the PicoBlaze execute stage and the interrupt
// sequencer: retire/decode information in, PC/stack/flag control out.
interface int_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              instr_done;
    logic [ADDR_W-1:0] pc_next;
    logic              eint;
    logic              dint;
    logic              returni;
    logic              returni_ie;
    logic              zero_in;
    logic              carry_in;

    logic              pc_load;
    logic [ADDR_W-1:0] pc_vector;
    logic              push_ret;
    logic [ADDR_W-1:0] ret_addr;
    logic              flag_restore;
    logic              zero_out;
    logic              carry_out;

    // Core side
    modport master (
        output instr_done, pc_next, eint, dint, returni, returni_ie, zero_in, carry_in,
        input  pc_load, pc_vector, push_ret, ret_addr, flag_restore, zero_out, carry_out
    );

    // Sequencer side
    modport slave (
        input  instr_done, pc_next, eint, dint, returni, returni_ie, zero_in, carry_in,
        output pc_load, pc_vector, push_ret, ret_addr, flag_restore, zero_out, carry_out
    );

endinterface

// File: rtl/int_ctrl.sv
// Interrupt sequencer: samples the pending level at instruction boundaries,
// vectors the core into the ISR and restores flags/enable on RETURNI.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] ISR_VECTOR = ADDR_W'(DEFAULT_ISR_VECTOR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          interrupt,
    output logic          ie,
    output logic          in_isr,
    output logic          interrupt_ack,
    int_ctrl_if.slave     bus
);

    state_t            state, state_d;
    logic              ie_d;
    logic              restore_d;
    logic [ADDR_W-1:0] ret_addr_d;
    logic              zero_d;
    logic              carry_d;

    assign bus.pc_vector = ISR_VECTOR;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state;
        ie_d       = ie;
        restore_d  = 1'b0;
        ret_addr_d = bus.ret_addr;
        zero_d     = bus.zero_out;
        carry_d    = bus.carry_out;

        case (state)
            IDLE: begin
                if (bus.instr_done) begin
                    // Acceptance looks at the registered enable, so a DINT retiring
                    // on the same boundary cannot block the pending interrupt.
                    if (interrupt && ie) begin
                        state_d    = ACK;
                        ie_d       = 1'b0;
                        ret_addr_d = bus.pc_next;
                        zero_d     = bus.zero_in;
                        carry_d    = bus.carry_in;
                    end else if (bus.returni) begin
                        restore_d = 1'b1;
                        ie_d      = bus.returni_ie;
                    end else begin
                        ie_d = ie_update(ie, bus.eint, bus.dint);
                    end
                end
            end

            ACK: begin
                state_d = ISR;
            end

            ISR: begin
                // No nesting: enable decodes and the pending level are ignored here.
                if (bus.instr_done && bus.returni) begin
                    state_d   = IDLE;
                    restore_d = 1'b1;
                    ie_d      = bus.returni_ie;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the
    // state they describe and never see a combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie               <= 1'b0;
            in_isr           <= 1'b0;
            interrupt_ack    <= 1'b0;
            bus.pc_load      <= 1'b0;
            bus.push_ret     <= 1'b0;
            bus.flag_restore <= 1'b0;
            bus.ret_addr     <= '0;
            bus.zero_out     <= 1'b0;
            bus.carry_out    <= 1'b0;
        end else begin
            ie               <= ie_d;
            in_isr           <= (state_d == ISR);
            interrupt_ack    <= (state_d == ACK);
            bus.pc_load      <= (state_d == ACK);
            bus.push_ret     <= (state_d == ACK);
            bus.flag_restore <= restore_d;
            bus.ret_addr     <= ret_addr_d;
            bus.zero_out     <= zero_d;
            bus.carry_out    <= carry_d;
        end
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

CPU-side interrupt sequencer for the emulated PicoBlaze core; consumer of the `interrupt` level produced by the set/reset interrupt flop. Tracks the interrupt-enable flag and samples `interrupt` at instruction boundaries. On acceptance it forces the program counter to the ISR vector, pushes the return address, preserves Z/C, and pulses `interrupt_ack` back to the flop's `reset` input. RETURNI restores flags and enable state.

## Interface
- `ADDR_W`, 12: program-address width.
- `ISR_VECTOR`, 12'hFFF: ISR entry address.
- `clk  in  1`: core clock; all state updates on rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `interrupt  in  1`: pending-interrupt level from the SR flop.
- `instr_done  in  1`: one-cycle pulse, current instruction retires; sampling point.
- `pc_next  in  ADDR_W`: address the core would fetch next; valid with `instr_done`.
- `eint  in  1`: ENABLE INTERRUPT decoded; valid with `instr_done`.
- `dint  in  1`: DISABLE INTERRUPT decoded; valid with `instr_done`.
- `returni  in  1`: RETURNI decoded; valid with `instr_done`.
- `returni_ie  in  1`: RETURNI operand; 1 = ENABLE, 0 = DISABLE.
- `zero_in`, `carry_in  in  1 each`: live core flags.
- `ie  out  1`: interrupt-enable state.
- `in_isr  out  1`: ISR active.
- `interrupt_ack  out  1`: one-cycle acknowledge; drives the flop's `reset`.
- `pc_load  out  1`: force PC to `pc_vector` this cycle.
- `pc_vector  out  ADDR_W`: constant `ISR_VECTOR`.
- `push_ret  out  1`: push `ret_addr` onto the call stack.
- `ret_addr  out  ADDR_W`: latched return address.
- `flag_restore  out  1`: load `zero_out`/`carry_out` into the core flags.
- `zero_out`, `carry_out  out  1 each`: saved flags.

## Operation
- States: IDLE, ACK, ISR.
- Reset values: state IDLE. `ie`, `in_isr`, `interrupt_ack`, `pc_load`, `push_ret`, `flag_restore`, `zero_out`, `carry_out` = 0. `ret_addr` = 0.
- IDLE, `instr_done`=1, `interrupt`=1, `ie`=1 (registered value, before this cycle's eint/dint) → ACK.
  - Latch `ret_addr`←`pc_next`, `zero_out`←`zero_in`, `carry_out`←`carry_in`.
  - Clear `ie`.
- IDLE, no acceptance: `dint` clears `ie`; else `eint` sets `ie`. Both asserted → dint wins.
- ACK: exactly one cycle; `interrupt_ack`=`pc_load`=`push_ret`=1; → ISR.
- ISR: `in_isr`=1. `eint`/`dint` ignored (no nesting). `interrupt` ignored.
- ISR, `instr_done`∧`returni` → IDLE; `flag_restore` pulses next cycle; `ie`←`returni_ie`.
- RETURNI in IDLE: same restore and `ie`←`returni_ie`; state stays IDLE.
- `instr_done`=0: no state, `ie` or latch change.
- `rst_n` low in any state, including ACK: immediate return to reset values; no partial ack or push pulse.

## Timing
- Acceptance latency: `instr_done` at edge N → `interrupt_ack`/`pc_load`/`push_ret` high N+1 to N+2, exactly one cycle.
- `interrupt` is cleared by the flop one cycle after `interrupt_ack`. This block never re-samples during ACK/ISR, so there is no double acceptance.
- `flag_restore` is a one-cycle pulse in the cycle after the RETURNI `instr_done`. `ie` updates on the same edge.
- `interrupt` still high after RETURNI ENABLE → accepted at the next `instr_done` (back-to-back service).
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package: state encoding constants (IDLE=2'd0, ACK=2'd1, ISR=2'd2), default `ISR_VECTOR`.
- Single module; no sub-module. Unused state encoding 2'd3 → IDLE.

## Test plan
- Reset: `rst_n`=0 with `interrupt`=1 → all outputs 0; after release, no ack while `ie`=0.
- Basic service: `eint`, then `interrupt`=1, `instr_done` with `pc_next`=12'h123, Z=1, C=0. Expect:
  - One-cycle `interrupt_ack`/`pc_load`/`push_ret`.
  - `ret_addr`=12'h123, `pc_vector`=12'hFFF.
  - `ie`=0, `in_isr`=1.
- Return: in ISR with Z=0, C=1 live, `returni`, `returni_ie`=1. Expect:
  - `flag_restore` pulse with `zero_out`=1, `carry_out`=0.
  - `ie`=1, state IDLE.
- Simultaneous: `ie`=1, `dint`+`interrupt` on the same `instr_done` → interrupt accepted (pre-update `ie`). `eint`+`dint` in IDLE → `ie`=0.
- No nesting: `eint` and `interrupt` during ISR → no second ack; `ie` stays 0.
- Reset mid-ACK: drop `rst_n` during the ACK cycle → ack and push deassert immediately; state IDLE, `ie`=0.
